// File: rtl/muscle_channel_scheduler.sv
// Time-multiplexes one shared muscle force datapath across NCH channels,
// holding each channel's difference-equation history and total force.

module muscle_channel_state (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] spikes_fp,
    input  logic [31:0] h_i,
    input  logic [31:0] t_next,
    output logic [31:0] s1,
    output logic [31:0] s2,
    output logic [31:0] h1,
    output logic [31:0] h2,
    output logic [31:0] t
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
            h1 <= '0;
            h2 <= '0;
            t  <= '0;
        end else if (we) begin
            s2 <= s1;
            s1 <= spikes_fp;
            h2 <= h1;
            h1 <= h_i;
            t  <= t_next;
        end
    end
endmodule

module muscle_channel_scheduler #(
    parameter int NCH  = 4,
    parameter int CH_W = 2,
    parameter int LAT  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_tick,
    input  logic [NCH-1:0]    i_ch_enable,
    input  logic [NCH*32-1:0] i_spike_cnt,
    output logic              dp_valid,
    output logic [CH_W-1:0]   dp_ch,
    output logic [31:0]       dp_spikes,
    output logic [31:0]       dp_spikes_i1,
    output logic [31:0]       dp_spikes_i2,
    output logic [31:0]       dp_h_i1,
    output logic [31:0]       dp_h_i2,
    output logic [31:0]       dp_T_i,
    input  logic [31:0]       dp_spikes_fp,
    input  logic [31:0]       dp_h_i,
    input  logic [31:0]       dp_T_next,
    input  logic [CH_W-1:0]   rd_addr,
    output logic [31:0]       rd_force,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun,
    input  logic              i_clr_overrun
);
    // Channel-indexed arrays are padded to 2**CH_W so any pointer value is a
    // legal index; padding slots read as zero and are never enabled.
    localparam int NSLOT = 1 << CH_W;

    // SCAN and WB are zero-cycle: folded into the IDLE/WAIT transitions.
    typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, WB, DONE} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                latch, wb_en;
    logic [CH_W:0]       first_hit, next_hit;

    logic [NCH-1:0][31:0]   spk_q;
    logic [NCH-1:0]         en_q;
    logic [NSLOT-1:0][31:0] spk_x, s1_a, s2_a, h1_a, h2_a, t_a;
    logic [NSLOT-1:0]       en_x, en_in_x;

    // Lowest set bit of m at or above 'from'; MSB of the result flags a hit.
    function automatic logic [CH_W:0] scan_from(input logic [NSLOT-1:0] m, input int from);
        logic [CH_W:0] r;
        r = '0;
        for (int i = NSLOT - 1; i >= 0; i--)
            if (m[i] && i >= from) r = {1'b1, CH_W'(i)};
        return r;
    endfunction

    for (genvar c = 0; c < NSLOT; c++) begin : g_ch
        if (c < NCH) begin : g_real
            muscle_channel_state u_st (
                .clk       (clk),
                .reset     (reset),
                .we        (wb_en && (ptr_q == CH_W'(c))),
                .spikes_fp (dp_spikes_fp),
                .h_i       (dp_h_i),
                .t_next    (dp_T_next),
                .s1        (s1_a[c]),
                .s2        (s2_a[c]),
                .h1        (h1_a[c]),
                .h2        (h2_a[c]),
                .t         (t_a[c])
            );
            assign spk_x[c]   = spk_q[c];
            assign en_x[c]    = en_q[c];
            assign en_in_x[c] = i_ch_enable[c];
        end else begin : g_pad
            assign s1_a[c]    = '0;
            assign s2_a[c]    = '0;
            assign h1_a[c]    = '0;
            assign h2_a[c]    = '0;
            assign t_a[c]     = '0;
            assign spk_x[c]   = '0;
            assign en_x[c]    = 1'b0;
            assign en_in_x[c] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spk_q <= '0;
            en_q  <= '0;
        end else if (latch) begin
            spk_q <= i_spike_cnt;
            en_q  <= i_ch_enable;
        end
    end

    assign first_hit = scan_from(en_in_x, 0);
    assign next_hit  = scan_from(en_x, int'(ptr_q) + 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        wb_en   = 1'b0;
        case (state_q)
            IDLE: if (i_tick) begin
                latch = 1'b1;
                ptr_d = '0;
                if (first_hit[CH_W]) begin
                    ptr_d   = first_hit[CH_W-1:0];
                    state_d = ISSUE;
                end else begin
                    state_d = DONE;
                end
            end
            ISSUE: begin
                cnt_d   = 4'(LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    wb_en = 1'b1;
                    if (next_hit[CH_W]) begin
                        ptr_d   = next_hit[CH_W-1:0];
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dp_valid     = (state_q == ISSUE);
    assign o_busy       = (state_q == ISSUE) || (state_q == WAIT);
    assign o_done       = (state_q == DONE);
    assign dp_ch        = ptr_q;
    assign dp_spikes    = spk_x[ptr_q];
    assign dp_spikes_i1 = s1_a[ptr_q];
    assign dp_spikes_i2 = s2_a[ptr_q];
    assign dp_h_i1      = h1_a[ptr_q];
    assign dp_h_i2      = h2_a[ptr_q];
    assign dp_T_i       = t_a[ptr_q];

    // A tick outside IDLE is dropped; the set takes priority over a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                           o_overrun <= 1'b0;
        else if (i_tick && state_q != IDLE)   o_overrun <= 1'b1;
        else if (i_clr_overrun)               o_overrun <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_force <= '0;
        else        rd_force <= t_a[rd_addr];
    end
endmodule

// File: tb/tb_muscle_channel_scheduler.sv
// Randomized sweeps of the channel scheduler against a per-channel history
// model with a scripted datapath responder.

module tb_muscle_channel_scheduler;
    localparam int NCH  = 4;
    localparam int CH_W = 2;
    localparam int LAT  = 3;

    logic              clk, reset, i_tick, i_clr_overrun;
    logic [NCH-1:0]    i_ch_enable;
    logic [NCH*32-1:0] i_spike_cnt;
    logic              dp_valid, o_busy, o_done, o_overrun;
    logic [CH_W-1:0]   dp_ch, rd_addr;
    logic [31:0]       dp_spikes, dp_spikes_i1, dp_spikes_i2, dp_h_i1, dp_h_i2, dp_T_i;
    logic [31:0]       dp_spikes_fp, dp_h_i, dp_T_next, rd_force;

    muscle_channel_scheduler #(.NCH(NCH), .CH_W(CH_W), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .i_tick(i_tick), .i_ch_enable(i_ch_enable),
        .i_spike_cnt(i_spike_cnt), .dp_valid(dp_valid), .dp_ch(dp_ch),
        .dp_spikes(dp_spikes), .dp_spikes_i1(dp_spikes_i1), .dp_spikes_i2(dp_spikes_i2),
        .dp_h_i1(dp_h_i1), .dp_h_i2(dp_h_i2), .dp_T_i(dp_T_i),
        .dp_spikes_fp(dp_spikes_fp), .dp_h_i(dp_h_i), .dp_T_next(dp_T_next),
        .rd_addr(rd_addr), .rd_force(rd_force), .o_busy(o_busy), .o_done(o_done),
        .o_overrun(o_overrun), .i_clr_overrun(i_clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_s1 [NCH];
    logic [31:0] m_s2 [NCH];
    logic [31:0] m_h1 [NCH];
    logic [31:0] m_h2 [NCH];
    logic [31:0] m_t  [NCH];
    bit          m_ovr;
    int          n_cmp, n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_junk;
        dp_spikes_fp = $urandom;
        dp_h_i       = $urandom;
        dp_T_next    = $urandom;
    endtask

    task automatic model_clear;
        for (int c = 0; c < NCH; c++) begin
            m_s1[c] = '0; m_s2[c] = '0; m_h1[c] = '0; m_h2[c] = '0; m_t[c] = '0;
        end
        m_ovr = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, dp_valid, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_ovr"}, o_overrun, m_ovr);
    endtask

    // One sweep: channel k of the enabled list issues in cycle 1+k*(LAT+1),
    // results are only valid on the inputs in cycle issue+LAT, DONE follows.
    task automatic sweep(input logic [NCH-1:0] en, input bit allow_ovr, input int abort_cyc);
        int          q[$];
        int          last, k, ph, ch, a;
        logic [31:0] m_spk [NCH];
        logic [31:0] rs, rh, rt, rexp;
        bit          tk, cl, wb;
        for (int c = 0; c < NCH; c++) begin
            m_spk[c] = $urandom;
            i_spike_cnt[c*32 +: 32] = m_spk[c];
            if (en[c]) q.push_back(c);
        end
        last = 1 + q.size() * (LAT + 1);
        i_tick = 1'b1; i_ch_enable = en; i_clr_overrun = 1'b0; drive_junk();
        a = $urandom_range(0, NCH-1); rd_addr = CH_W'(a); rexp = m_t[a];
        step();
        chk("rd_tick", rd_force, rexp);
        i_tick = 1'b0;
        i_ch_enable = NCH'($urandom);
        for (int c = 0; c < NCH; c++) i_spike_cnt[c*32 +: 32] = $urandom;
        for (int cyc = 1; cyc <= last; cyc++) begin
            if (cyc == abort_cyc) begin
                reset = 1'b0;
                #1;
                model_clear();
                chk("rst_valid", dp_valid, 0);
                chk("rst_ch", dp_ch, 0);
                chk("rst_busy", o_busy, 0);
                chk("rst_done", o_done, 0);
                chk("rst_ovr", o_overrun, 0);
                chk("rst_rd", rd_force, 0);
                step();
                reset = 1'b1;
                return;
            end
            ch = 0; ph = -1;
            if (cyc == last) begin
                chk("done", o_done, 1);
                chk("done_busy", o_busy, 0);
                chk("done_valid", dp_valid, 0);
            end else begin
                k = (cyc - 1) / (LAT + 1);
                ph = (cyc - 1) % (LAT + 1);
                ch = q[k];
                chk("valid", dp_valid, (ph == 0));
                chk("busy", o_busy, 1);
                chk("ndone", o_done, 0);
                chk("ch", dp_ch, ch);
                chk("spikes", dp_spikes, m_spk[ch]);
                chk("s1", dp_spikes_i1, m_s1[ch]);
                chk("s2", dp_spikes_i2, m_s2[ch]);
                chk("h1", dp_h_i1, m_h1[ch]);
                chk("h2", dp_h_i2, m_h2[ch]);
                chk("T", dp_T_i, m_t[ch]);
            end
            chk("ovr", o_overrun, m_ovr);
            tk = allow_ovr && ($urandom_range(0, 5) == 0);
            cl = ($urandom_range(0, 7) == 0);
            i_tick = tk; i_clr_overrun = cl;
            wb = (ph == LAT);
            if (wb) begin
                rs = $urandom; rh = $urandom; rt = $urandom;
                dp_spikes_fp = rs; dp_h_i = rh; dp_T_next = rt;
                a = ch;
            end else begin
                drive_junk();
                a = $urandom_range(0, NCH-1);
            end
            rd_addr = CH_W'(a); rexp = m_t[a];
            step();
            chk("rd", rd_force, rexp);
            m_ovr = tk ? 1'b1 : (cl ? 1'b0 : m_ovr);
            if (wb) begin
                m_s2[ch] = m_s1[ch]; m_s1[ch] = rs;
                m_h2[ch] = m_h1[ch]; m_h1[ch] = rh;
                m_t[ch]  = rt;
            end
        end
        i_tick = 1'b0; i_clr_overrun = 1'b0;
        check_idle_outputs("post");
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b0; i_tick = 1'b0; i_clr_overrun = 1'b0; i_ch_enable = '0;
        i_spike_cnt = '0; rd_addr = '0; drive_junk();
        model_clear();
        repeat (3) step();
        check_idle_outputs("reset");
        chk("reset_ch", dp_ch, 0);
        chk("reset_rd", rd_force, 0);
        reset = 1'b1;
        step();
        check_idle_outputs("rel");

        sweep(4'b1111, 1'b0, 0);
        sweep(4'b1111, 1'b0, 0);
        sweep(4'b1010, 1'b0, 0);
        sweep(4'b0000, 1'b0, 0);
        sweep(4'b0100, 1'b0, 0);
        sweep(4'b1111, 1'b1, 0);

        // abort during channel 1 WAIT
        sweep(4'b1111, 1'b0, LAT + 3);
        rd_addr = '0;
        step();
        chk("rd_after_rst", rd_force, 0);
        sweep(4'b1111, 1'b0, 0);

        for (int r = 0; r < 24; r++) sweep(NCH'($urandom), 1'b1, 0);

        i_tick = 1'b0;
        i_clr_overrun = 1'b1;
        step();
        m_ovr = 1'b0;
        i_clr_overrun = 1'b0;
        chk("ovr_clr", o_overrun, 0);

        for (int c = 0; c < NCH; c++) begin
            rd_addr = CH_W'(c);
            step();
            chk("rd_final", rd_force, m_t[c]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/muscle_channel_scheduler.md
Name: muscle_channel_scheduler

Overview:
- Time-multiplexes one shared muscle force datapath across NCH muscle channels: int-to-float spike conversion, fuglevand twitch filter, s_weight, d_force and integrator.
- Holds every channel's difference-equation history and total-force state.
- On each simulation tick, sequences all enabled channels through the datapath, one at a time, and writes the results back.
- Sits between the spike-count sources and the single shared force pipeline, replacing per-channel datapath copies.

Parameters:
NCH, 4, number of muscle channels (2..16)
CH_W, 2, channel index width, equal to clog2(NCH)
LAT, 3, datapath latency in cycles from issue to result (1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
i_tick  in  1  one-cycle pulse that starts a sweep
i_ch_enable  in  NCH  per-channel enable, sampled at tick
i_spike_cnt  in  NCH*32  integer spike counts; channel c at bits [32c+31:32c]; sampled at tick
dp_valid  out  1  one-cycle issue strobe to the datapath
dp_ch  out  CH_W  channel being issued/serviced
dp_spikes  out  32  integer spike count of the serviced channel
dp_spikes_i1, dp_spikes_i2  out  32 each  float spike history of the serviced channel
dp_h_i1, dp_h_i2  out  32 each  float twitch history of the serviced channel
dp_T_i  out  32  float total force of the serviced channel
dp_spikes_fp  in  32  converted spike value returned by the datapath
dp_h_i  in  32  new twitch output returned by the datapath
dp_T_next  in  32  integrated total force returned by the datapath
rd_addr  in  CH_W  readback channel select
rd_force  out  32  registered T of channel rd_addr
o_busy  out  1  sweep in progress
o_done  out  1  one-cycle pulse at the end of a sweep
o_overrun  out  1  sticky flag: a tick arrived while busy
i_clr_overrun  in  1  clears o_overrun

Behaviour:
- Reset (reset=0, asynchronous):
  - All per-channel state (s1, s2, h1, h2, T) = 32'h0.
  - Sampled spike and enable latches = 0.
  - FSM goes to IDLE.
  - dp_valid=0, dp_ch=0, o_busy=0, o_done=0, o_overrun=0, rd_force=0.
  - Reset mid-sweep aborts the sweep; no partial writeback survives.
- FSM states: IDLE, SCAN, ISSUE, WAIT, WB, DONE.
- IDLE:
  - i_tick=1 latches i_spike_cnt and i_ch_enable, sets channel pointer to 0, goes to SCAN.
  - If no channel is enabled, goes directly to DONE.
- SCAN (combinational skip, 0 cycles):
  - Advances the pointer to the next enabled channel at or after the current one.
  - Disabled channels consume no cycles and keep their state unchanged.
- ISSUE (1 cycle):
  - dp_valid=1; dp_ch plus all dp_* operands reflect the pointed channel.
  - Load the latency counter with LAT-1 (fires immediately when LAT=1).
- WAIT:
  - dp_ch and operands stay stable; the counter decrements.
  - When the counter reaches 0, go to WB.
  - Result inputs are sampled at the end of the cycle issued+LAT.
- WB (same edge as the WAIT exit, no extra cycle):
  - s2<=s1, s1<=dp_spikes_fp, h2<=h1, h1<=dp_h_i, T<=dp_T_next.
  - If more enabled channels remain, go to ISSUE for the next channel; otherwise go to DONE.
- Cost per enabled channel: exactly LAT+1 cycles.
- Sweep timing (E = number of enabled channels):
  - tick sampled at edge t; first ISSUE in cycle t+1.
  - DONE in cycle t+1+E*(LAT+1); o_done=1 for that cycle; then IDLE.
  - o_busy=1 from cycle t+1 through the last WAIT cycle; 0 in DONE.
  - E=0: DONE in cycle t+1.
- Ticks outside IDLE:
  - i_tick while not IDLE (including the DONE cycle) is ignored and sets o_overrun.
  - i_clr_overrun clears it; if the clear and a new overrun coincide, the set wins.
- rd_force: registered 1 cycle after rd_addr. If rd_addr addresses a channel being written on the same edge, the old T is returned.
- Out-of-range rd_addr (>=NCH): rd_force=0.
- Datapath values are IEEE-754 single, passed unchanged; the scheduler performs no arithmetic on them.
- dp_spikes carries the raw integer spike count.

Test Plan:
- Reset: hold reset=0, then release; tick with 4 enabled channels, LAT=3 → dp_valid pulses in cycles 1, 5, 9, 13 after the tick; dp_ch=0,1,2,3; all history operands 0; o_done in cycle 17.
- Writeback/history: model returns dp_spikes_fp=32'h3F800000, dp_h_i=32'h40000000, dp_T_next=32'h40400000 for channel 2. On the next sweep, channel 2 issue shows s1=3F800000, h1=40000000, T_i=40400000, s2=h2=0. After a third sweep, s2=3F800000.
- Enable skip: i_ch_enable=4'b1010 → only channels 1 and 3 issued, in cycles 1 and 5; o_done in cycle 9; channel 0 and 2 state unchanged.
- Overrun: tick again 3 cycles after the first tick → o_overrun=1, no restart, sweep completes normally; i_clr_overrun → 0.
- Reset mid-sweep: assert reset during channel 1 WAIT → all outputs 0 immediately; rd_force of channel 0 reads 0 afterwards.
- Empty sweep and readback: i_ch_enable=0 → o_done in cycle 1, o_busy never high; rd_addr=3 → rd_force equals the last written T on the next cycle.
